// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one reset-less uart_tx among N_REQ byte requesters.
// Latency: accept edge -> tx_start next cycle; tx_start pulses spaced >= FRAME_CYCLES+2 cycles.
// Backpressure: req_ready only in IDLE, one-hot; requesters hold valid/data until accepted.
module uart_tx_sched #(
    parameter int N_REQ        = 4,
    parameter int FRAME_CYCLES = 52100,
    parameter int CNT_W        = $clog2(FRAME_CYCLES + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [8*N_REQ-1:0]         req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       tx_start,
    output logic [7:0]                 tx_data,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       busy
);

    localparam int GW = $clog2(N_REQ);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

    typedef enum logic [1:0] {
        FLUSH,
        IDLE,
        SEND,
        WAIT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [GW-1:0]    rr_ptr;

    logic             found;
    logic [GW-1:0]    sel_idx;
    logic [N_REQ-1:0] sel_oh;

    // Search starts just after the last grant so that requester drops to lowest priority.
    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        sel_oh  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found && req_valid[(int'(rr_ptr) + k) % N_REQ]) begin
                found   = 1'b1;
                sel_idx = GW'((int'(rr_ptr) + k) % N_REQ);
            end
        end
        sel_oh[sel_idx] = found;
        req_ready = (state == IDLE) ? sel_oh : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FLUSH;
            cnt      <= '0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            grant_id <= '0;
            rr_ptr   <= GW'(N_REQ - 1);
            busy     <= 1'b1;
        end else begin
            case (state)
                // FLUSH covers a frame the transmitter may still be sending across our reset.
                FLUSH, WAIT: begin
                    if (cnt == CNT_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (found) begin
                        tx_data  <= req_data[8*sel_idx +: 8];
                        grant_id <= sel_idx;
                        rr_ptr   <= sel_idx;
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    tx_start <= 1'b0;
                    cnt      <= '0;
                    state    <= WAIT;
                end
                default: state <= FLUSH;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized bench for uart_tx_sched against a timeline model (grant times, idle times, RR order).
module tb_uart_tx_sched;
    localparam int N  = 4;
    localparam int FC = 20;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic [1:0]     grant_id;
    logic           busy;

    uart_tx_sched #(.N_REQ(N), .FRAME_CYCLES(FC)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
        .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle)", tag, obs, exp);
        end
    endtask

    // Model: cycle index since reset release, when IDLE begins, when tx_start is due.
    int         c, rr, idle_at, start_at, m_gid, last_start, mode;
    logic [7:0] m_data;
    logic [N-1:0] pend = '0;
    logic [7:0] pbyte [N];
    bit         a5_done = 0;

    function automatic logic [N-1:0] exp_ready();
        logic [N-1:0] r;
        r = '0;
        if (c >= idle_at) begin
            for (int k = 1; k <= N; k++) begin
                if (r == '0 && pend[(rr + k) % N]) r[(rr + k) % N] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd1);
        chk("rst_req_ready", {28'd0, req_ready}, 32'd0);
        chk("rst_grant_id", {30'd0, grant_id}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        c = 0; rr = N - 1; idle_at = FC; start_at = -1;
        m_data = 8'h00; m_gid = 0; last_start = -1;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (!pend[i]) begin
                case (mode)
                    0: if ($urandom_range(0, 7) == 0) begin pend[i] = 1'b1; pbyte[i] = 8'($urandom); end
                    1: begin pend[i] = 1'b1; pbyte[i] = 8'h10 + 8'(i); end
                    2: if (i == 0 || i == 3) begin pend[i] = 1'b1; pbyte[i] = 8'($urandom); end
                    default: if (i == 0 && c == 2 && !a5_done) begin
                        pend[i] = 1'b1; pbyte[i] = 8'hA5; a5_done = 1;
                    end
                endcase
            end
        end
        req_valid = pend;
        for (int i = 0; i < N; i++) req_data[8*i +: 8] = pend[i] ? pbyte[i] : 8'($urandom);
    endtask

    task automatic step();
        logic [N-1:0] er;
        int acc;
        acc = -1;
        drive();
        @(negedge clk);
        er = exp_ready();
        chk("req_ready", {28'd0, req_ready}, {28'd0, er});
        chk("busy", {31'd0, busy}, {31'd0, c < idle_at});
        chk("tx_start", {31'd0, tx_start}, {31'd0, c == start_at});
        chk("tx_data", {24'd0, tx_data}, {24'd0, m_data});
        chk("grant_id", {30'd0, grant_id}, 32'(m_gid));
        if (tx_start === 1'b1) begin
            if (mode == 1 && last_start >= 0) chk("start_spacing", 32'(c - last_start), 32'(FC + 2));
            last_start = c;
        end
        for (int i = 0; i < N; i++) if (er[i]) acc = i;
        if (acc >= 0) begin
            m_data = pbyte[acc]; m_gid = acc; rr = acc;
            start_at = c + 1; idle_at = c + 2 + FC;
        end
        @(posedge clk);
        #1;
        c++;
        if (acc >= 0) pend[acc] = 1'b0;
    endtask

    initial begin
        mode = 3;
        @(posedge clk);
        #1;
        do_reset();
        repeat (50) step();
        mode = 1; last_start = -1;
        repeat (130) step();
        do_reset();
        repeat (30) step();
        mode = 2; last_start = -1;
        repeat (100) step();
        mode = 0;
        for (int n = 0; n < 2500; n++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            step();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
